id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the five-stage MIPS pipeline. It holds the IF/ID pipeline register, the 32×32 register file, main control decode, load-use hazard detection and branch/jump resolution. Its decoded outputs drive the ID/EX register inputs directly, and its PC-control outputs steer the fetch stage.

## Interface
Parameters:
- none (widths fixed: 32-bit datapath, 5-bit register addresses)

Ports:
- clk_i  in  1  pipeline clock, all state updates on rising edge
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- if_pc4_i  in  32  PC+4 of the fetched instruction
- if_instr_i  in  32  fetched instruction
- ex_memread_i  in  1  MemRead of the instruction currently in EX (ID/EX output)
- ex_rtaddr_i  in  5  RT address of the instruction currently in EX
- wb_regwrite_i  in  1  writeback enable
- wb_rdaddr_i  in  5  writeback register address
- wb_data_i  in  32  writeback data
- pc_write_o  out  1  0 freezes the PC
- pc_src_o  out  2  00 = PC+4, 01 = branch target, 10 = jump target
- branch_target_o  out  32  branch target
- jump_target_o  out  32  jump target
- regwrite_o, memtoreg_o, memread_o, memwrite_o, regdst_o, alusrc_o  out  1 each  control to ID/EX
- aluop_o  out  2  00 = add, 01 = sub/compare, 10 = R-type funct
- addr_o  out  32  IF/ID PC+4
- rsdata_o, rtdata_o  out  32  register file read data
- sign_extend_o  out  32  sign-extended instr[15:0]
- rsaddr_o, rtaddr_o, rdaddr_o  out  5  instr[25:21], [20:16], [15:11]

## Operation
- **IF/ID register** (pc4, instr). Per clock edge, in priority order:
  - rst_i: clear to 0 (the nop).
  - flush: load 0.
  - stall: hold.
  - otherwise: load if_* inputs.
- **Decode** is combinational from the IF/ID instr:
  - R-type (op 000000): regwrite, regdst, aluop 10.
  - addi (001000): regwrite, alusrc, aluop 00.
  - lw (100011): regwrite, memtoreg, memread, alusrc, aluop 00.
  - sw (101011): memwrite, alusrc, aluop 00.
  - beq (000100): aluop 01, branch.
  - j (000010): jump.
  - Any other opcode: all control outputs 0.
- **Load-use stall** = ex_memread_i AND ex_rtaddr_i ≠ 0 AND (ex_rtaddr_i == rs OR ex_rtaddr_i == rt), for every opcode except j.
  - During a stall, all control outputs are forced to 0 (bubble), pc_write_o = 0 and pc_src_o = 00.
- **Branch/jump** are resolved in ID. This stage has no forwarding; the register-file write-through is the only bypass.
  - beq is taken when rsdata_o == rtdata_o: pc_src_o = 01.
  - j: pc_src_o = 10.
  - flush = (beq taken OR j) AND NOT stall.
  - Stall has priority: a branch or jump that coincides with a stall is not taken and is re-evaluated next cycle.
- **Register file** (sub-module):
  - Write on rising edge when wb_regwrite_i AND wb_rdaddr_i ≠ 0.
  - r0 always reads 0.
  - Write-through: a read of the register being written this cycle returns wb_data_i.
- **Arithmetic**:
  - sign_extend_o = {16{instr[15]}, instr[15:0]}.
  - branch_target_o = pc4 + (sign_extend << 2), modulo 2^32.
  - jump_target_o = {pc4[31:28], instr[25:0], 2'b00}.

## Timing
- **Latency**: if_* inputs sampled at edge N produce decoded outputs valid after edge N, combinationally stable before edge N+1, where ID/EX captures them.
- **Reset**:
  - IF/ID cleared and all 32 registers cleared.
  - All control outputs 0, addresses/data 0, pc_src_o = 00, pc_write_o = 1.
  - Reset beats a simultaneous writeback (the write is dropped).
  - Reset mid-stall or mid-flush clears state on that edge.
- **Stall**: lasts exactly one cycle per load-use pair. On the next cycle the load has left EX, so the stall deasserts without a counter.
- **Flush**: inserts exactly one nop into IF/ID. The instruction in ID (beq/j) still passes its control to ID/EX.
- **Simultaneous stall and writeback**: the write still occurs.

## Structure
- Package id_pkg holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J)
  - ALUOp encodings
  - pc_src encodings (PCSRC_SEQ, PCSRC_BR, PCSRC_J)
- Sub-module reg_file: 2 read ports, 1 write port, write-through, synchronous reset. Hazard and decode logic stay in id_stage.

## Test plan
1. Reset, then idle: all outputs 0 except pc_write_o = 1; read r5 → 0.
2. WB writes r3 = 0x1234 while ID reads r3: rsdata_o = 0x1234 the same cycle. Write to r0 = 0xFFFF: r0 still reads 0.
3. lw r2 in EX (ex_memread_i = 1, ex_rtaddr_i = 2), ID holds add r4, r2, r1:
   - pc_write_o = 0 and control outputs 0 for one cycle, IF/ID held.
   - Next cycle regwrite_o = 1, regdst_o = 1, aluop_o = 10.
4. beq r1, r1, offset −1 at pc4 = 0x100: pc_src_o = 01, branch_target_o = 0x0FC; next IF/ID = nop.
5. j 0x0000040 at pc4 = 0x80000004: jump_target_o = 0x80000100, pc_src_o = 10, one flush. Also check beq concurrent with a load-use stall: pc_src_o = 00 until the stall clears.
6. Assert rst_i during a stall with WB active: all state cleared next edge, and the written register reads 0.

Source files
------------

// File: rtl/id_pkg.sv
// id_pkg: shared constants and bundles for the MIPS decode stage.
// Holds opcodes, ALUOp and pc_src encodings, and the control bundle type.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       regdst;
    logic       alusrc;
    logic [1:0] aluop;
    logic       branch;
    logic       jump;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

endpackage

// File: rtl/id_stage_reg_file.sv
// reg_file: 32x32 register file, two read ports, one write port.
// Ports: clk/rst (sync, active-high), we/waddr/wdata, raddr_a/b -> rdata_a/b.
module reg_file
  import id_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);

  logic [31:0] regs [32];
  logic        wr_en;

  assign wr_en = we && (waddr != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  // Write-through lets ID see a value retiring in WB this same cycle.
  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
    if (wr_en && waddr == raddr_a) rdata_a = wdata;
    if (wr_en && waddr == raddr_b) rdata_b = wdata;
    if (raddr_a == 5'd0) rdata_a = '0;
    if (raddr_b == 5'd0) rdata_b = '0;
  end

endmodule

// File: rtl/id_stage.sv
// id_stage: IF/ID register, register file, control decode, load-use
// hazard and branch/jump resolution; outputs feed ID/EX and steer fetch.
module id_stage
  import id_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] if_pc4_i,
  input  logic [31:0] if_instr_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_rtaddr_i,
  input  logic        wb_regwrite_i,
  input  logic [4:0]  wb_rdaddr_i,
  input  logic [31:0] wb_data_i,
  output logic        pc_write_o,
  output logic [1:0]  pc_src_o,
  output logic [31:0] branch_target_o,
  output logic [31:0] jump_target_o,
  output logic        regwrite_o,
  output logic        memtoreg_o,
  output logic        memread_o,
  output logic        memwrite_o,
  output logic        regdst_o,
  output logic        alusrc_o,
  output logic [1:0]  aluop_o,
  output logic [31:0] addr_o,
  output logic [31:0] rsdata_o,
  output logic [31:0] rtdata_o,
  output logic [31:0] sign_extend_o,
  output logic [4:0]  rsaddr_o,
  output logic [4:0]  rtaddr_o,
  output logic [4:0]  rdaddr_o
);

  if_id_t ifid;
  ctrl_t  ctrl;
  ctrl_t  ctrl_q;
  logic   stall;
  logic   taken;
  logic   flush;
  logic [5:0] op;

  assign op       = ifid.instr[31:26];
  assign rsaddr_o = ifid.instr[25:21];
  assign rtaddr_o = ifid.instr[20:16];
  assign rdaddr_o = ifid.instr[15:11];
  assign addr_o   = ifid.pc4;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ifid <= '0;
    end else if (flush) begin
      ifid <= '0;
    end else if (!stall) begin
      ifid <= '{pc4: if_pc4_i, instr: if_instr_i};
    end
  end

  reg_file u_rf (
    .clk     (clk_i),
    .rst     (rst_i),
    .we      (wb_regwrite_i),
    .waddr   (wb_rdaddr_i),
    .wdata   (wb_data_i),
    .raddr_a (rsaddr_o),
    .raddr_b (rtaddr_o),
    .rdata_a (rsdata_o),
    .rdata_b (rtdata_o)
  );

  // The all-zero word is the pipeline nop: it decodes to no control,
  // so reset and flush bubbles drive zeros into ID/EX.
  always_comb begin
    ctrl = '0;
    unique case (1'b1)
      (op == OP_RTYPE && ifid.instr != '0): begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        ctrl.aluop    = ALUOP_FUNCT;
      end
      (op == OP_ADDI): begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
      end
      (op == OP_LW): begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
      end
      (op == OP_SW): begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
      end
      (op == OP_BEQ): begin
        ctrl.aluop  = ALUOP_SUB;
        ctrl.branch = 1'b1;
      end
      (op == OP_J): begin
        ctrl.jump = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign stall = ex_memread_i
              && (ex_rtaddr_i != 5'd0)
              && ((ex_rtaddr_i == rsaddr_o)
               || (ex_rtaddr_i == rtaddr_o))
              && !ctrl.jump;

  assign taken = ctrl.branch && (rsdata_o == rtdata_o);
  assign flush = (taken || ctrl.jump) && !stall;

  assign ctrl_q = stall ? ctrl_t'('0) : ctrl;

  assign regwrite_o = ctrl_q.regwrite;
  assign memtoreg_o = ctrl_q.memtoreg;
  assign memread_o  = ctrl_q.memread;
  assign memwrite_o = ctrl_q.memwrite;
  assign regdst_o   = ctrl_q.regdst;
  assign alusrc_o   = ctrl_q.alusrc;
  assign aluop_o    = ctrl_q.aluop;

  assign pc_write_o = !stall;

  // A stalled branch/jump is simply re-evaluated on the next cycle.
  always_comb begin
    pc_src_o = PCSRC_SEQ;
    if (!stall) begin
      if (ctrl.jump)  pc_src_o = PCSRC_J;
      else if (taken) pc_src_o = PCSRC_BR;
    end
  end

  assign sign_extend_o   = {{16{ifid.instr[15]}}, ifid.instr[15:0]};
  assign branch_target_o = ifid.pc4 + {sign_extend_o[29:0], 2'b00};
  assign jump_target_o   = {ifid.pc4[31:28], ifid.instr[25:0], 2'b00};

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed + randomized checks of id_stage against a
// behavioural model of the IF/ID register, register file and decode rules.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc4;
  logic [31:0] if_instr;
  logic        ex_memread;
  logic [4:0]  ex_rtaddr;
  logic        wb_regwrite;
  logic [4:0]  wb_rdaddr;
  logic [31:0] wb_data;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        regwrite, memtoreg, memread, memwrite, regdst, alusrc;
  logic [1:0]  aluop;
  logic [31:0] addr, rsdata, rtdata, sext;
  logic [4:0]  rsaddr, rtaddr, rdaddr;

  int total = 0;
  int bad = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc4;
  logic [31:0] m_instr;
  logic        e_stall = 1'b0;
  logic        e_flush = 1'b0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .if_pc4_i        (if_pc4),
    .if_instr_i      (if_instr),
    .ex_memread_i    (ex_memread),
    .ex_rtaddr_i     (ex_rtaddr),
    .wb_regwrite_i   (wb_regwrite),
    .wb_rdaddr_i     (wb_rdaddr),
    .wb_data_i       (wb_data),
    .pc_write_o      (pc_write),
    .pc_src_o        (pc_src),
    .branch_target_o (branch_target),
    .jump_target_o   (jump_target),
    .regwrite_o      (regwrite),
    .memtoreg_o      (memtoreg),
    .memread_o       (memread),
    .memwrite_o      (memwrite),
    .regdst_o        (regdst),
    .alusrc_o        (alusrc),
    .aluop_o         (aluop),
    .addr_o          (addr),
    .rsdata_o        (rsdata),
    .rtdata_o        (rtdata),
    .sign_extend_o   (sext),
    .rsaddr_o        (rsaddr),
    .rtaddr_o        (rtaddr),
    .rdaddr_o        (rdaddr)
  );

  function automatic logic [31:0] rtype(input logic [4:0] s, t, d);
    return {6'd0, s, t, d, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] o,
                                        input logic [4:0] s, t,
                                        input logic [15:0] imm);
    return {o, s, t, imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [25:0] tg);
    return {6'b000010, tg};
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_regwrite && wb_rdaddr == a) return wb_data;
    return m_regs[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ctl_now();
    return {regwrite, memtoreg, memread, memwrite,
            regdst, alusrc, aluop};
  endfunction

  task automatic check_all();
    logic [5:0]  op;
    logic [4:0]  s, t;
    logic [31:0] rsd, rtd, se, bt, jt;
    logic [7:0]  ctl;
    logic        tk, jp;
    logic [1:0]  ps;
    op  = m_instr[31:26];
    s   = m_instr[25:21];
    t   = m_instr[20:16];
    rsd = mread(s);
    rtd = mread(t);
    e_stall = ex_memread && ex_rtaddr != 5'd0
           && (ex_rtaddr == s || ex_rtaddr == t)
           && op != 6'b000010;
    case (op)
      6'b000000: ctl = (m_instr == 32'd0) ? 8'h00 : 8'b10001010;
      6'b001000: ctl = 8'b10000100;
      6'b100011: ctl = 8'b11100100;
      6'b101011: ctl = 8'b00010100;
      6'b000100: ctl = 8'b00000001;
      default:   ctl = 8'h00;
    endcase
    if (e_stall) ctl = 8'h00;
    tk = (op == 6'b000100) && (rsd == rtd);
    jp = (op == 6'b000010);
    ps = e_stall ? 2'd0 : jp ? 2'd2 : tk ? 2'd1 : 2'd0;
    e_flush = (tk || jp) && !e_stall;
    se = {{16{m_instr[15]}}, m_instr[15:0]};
    bt = m_pc4 + se * 4;
    jt = {m_pc4[31:28], m_instr[25:0], 2'b00};
    chk("pc_write", 32'(pc_write), 32'(!e_stall));
    chk("pc_src", 32'(pc_src), 32'(ps));
    chk("ctrl", 32'(ctl_now()), 32'(ctl));
    chk("addr", addr, m_pc4);
    chk("rsdata", rsdata, rsd);
    chk("rtdata", rtdata, rtd);
    chk("sext", sext, se);
    chk("br_tgt", branch_target, bt);
    chk("j_tgt", jump_target, jt);
    chk("regs", {17'd0, rsaddr, rtaddr, rdaddr},
        {17'd0, m_instr[25:11]});
  endtask

  task automatic drive(input logic r, input logic [31:0] pc4, ins,
                       input logic mr, input logic [4:0] ert,
                       input logic we, input logic [4:0] wrd,
                       input logic [31:0] wd);
    rst = r;
    if_pc4 = pc4;
    if_instr = ins;
    ex_memread = mr;
    ex_rtaddr = ert;
    wb_regwrite = we;
    wb_rdaddr = wrd;
    wb_data = wd;
    #1;
    check_all();
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_pc4 = 32'd0;
      m_instr = 32'd0;
    end else begin
      if (wb_regwrite && wb_rdaddr != 5'd0) m_regs[wb_rdaddr] = wb_data;
      if (e_flush) begin
        m_pc4 = 32'd0;
        m_instr = 32'd0;
      end else if (!e_stall) begin
        m_pc4 = if_pc4;
        m_instr = if_instr;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] beq_m1, beq_p3, ins;
    logic [5:0]  ops [7];
    beq_m1 = itype(6'b000100, 5'd1, 5'd1, 16'hFFFF);
    beq_p3 = itype(6'b000100, 5'd2, 5'd2, 16'h0003);
    ops = '{6'b000000, 6'b001000, 6'b100011, 6'b101011,
            6'b000100, 6'b000010, 6'b111111};
    rst = 1'b1;
    if_pc4 = '0;
    if_instr = '0;
    ex_memread = 1'b0;
    ex_rtaddr = '0;
    wb_regwrite = 1'b0;
    wb_rdaddr = '0;
    wb_data = '0;
    @(negedge clk);
    adv();

    drive(0, 32'h4, rtype(3, 5, 7), 0, 0, 0, 0, 0);
    chk("rst_pcw", 32'(pc_write), 32'd1);
    chk("rst_ctl", 32'(ctl_now()), 32'd0);
    chk("rst_src", 32'(pc_src), 32'd0);
    adv();

    drive(0, 32'h8, rtype(0, 3, 1), 0, 0, 1, 5'd3, 32'h1234);
    chk("wt_r3", rsdata, 32'h1234);
    chk("rd_r5", rtdata, 32'd0);
    adv();

    drive(0, 32'h8, rtype(0, 3, 1), 0, 0, 1, 5'd0, 32'hFFFF);
    chk("r0_zero", rsdata, 32'd0);
    chk("r3_kept", rtdata, 32'h1234);
    adv();

    drive(0, 32'hC, rtype(2, 1, 4), 0, 0, 1, 5'd1, 32'd5);
    adv();
    adv();

    drive(0, 32'h10, itype(6'b001000, 5'd1, 5'd1, 16'd1),
          1, 5'd2, 1, 5'd2, 32'd7);
    chk("lu_pcw", 32'(pc_write), 32'd0);
    chk("lu_ctl", 32'(ctl_now()), 32'd0);
    adv();

    drive(0, 32'h100, beq_m1, 0, 0, 0, 0, 0);
    chk("lu_held", addr, 32'hC);
    chk("lu_ctl2", 32'(ctl_now()), 32'b10001010);
    adv();

    drive(0, 32'h104, itype(6'b001000, 5'd1, 5'd1, 16'd9),
          0, 0, 0, 0, 0);
    chk("beq_src", 32'(pc_src), 32'd1);
    chk("beq_tgt", branch_target, 32'h0FC);
    adv();

    drive(0, 32'h80000004, jtype(26'h40), 0, 0, 0, 0, 0);
    chk("fl_nop", m_instr, 32'(ctl_now()));
    chk("fl_addr", addr, 32'd0);
    adv();

    drive(0, 32'h200, beq_p3, 0, 0, 0, 0, 0);
    chk("j_tgt_d", jump_target, 32'h80000100);
    chk("j_src", 32'(pc_src), 32'd2);
    adv();

    drive(0, 32'h200, beq_p3, 0, 0, 0, 0, 0);
    chk("j_nop", addr, 32'd0);
    adv();

    drive(0, 32'h200, beq_p3, 1, 5'd2, 0, 0, 0);
    chk("bs_src", 32'(pc_src), 32'd0);
    chk("bs_pcw", 32'(pc_write), 32'd0);
    adv();

    drive(0, 32'h300, rtype(3, 5, 6), 0, 0, 0, 0, 0);
    chk("bs_src2", 32'(pc_src), 32'd1);
    chk("bs_tgt", branch_target, 32'h20C);
    adv();

    drive(0, 32'h300, rtype(3, 5, 6), 0, 0, 0, 0, 0);
    adv();

    drive(1, 32'h400, rtype(9, 3, 1), 1, 5'd3, 1, 5'd9, 32'hABCD);
    adv();

    drive(0, 32'h10, rtype(9, 3, 1), 0, 0, 0, 0, 0);
    chk("rs_addr", addr, 32'd0);
    chk("rs_ctl", 32'(ctl_now()), 32'd0);
    adv();

    drive(0, 32'h10, rtype(9, 3, 1), 0, 0, 0, 0, 0);
    chk("rs_r9", rsdata, 32'd0);
    chk("rs_r3", rtdata, 32'd0);
    adv();

    for (int n = 0; n < 400; n++) begin
      logic [4:0] s, t;
      logic [5:0] o;
      o = ops[$urandom_range(0, 6)];
      s = 5'($urandom_range(0, 7));
      t = ($urandom_range(0, 3) == 0) ? s : 5'($urandom_range(0, 7));
      if (o == 6'b000010) ins = {o, 26'($urandom)};
      else ins = {o, s, t, 16'($urandom)};
      drive($urandom_range(0, 49) == 0, $urandom, ins,
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
            1'($urandom), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3))
                                        : $urandom);
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
